// File: rtl/reg_buffer.sv
// Registered FIFO buffer: push visible on out_data one cycle later, no comb in->out path.
// in_ready depends only on registered count, so a full buffer refuses pushes even while popping.
module reg_buffer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             push, pop;

  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign ovf         = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      // DEPTH is a power of 2, so pointer overflow is the modulo wrap
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (in_valid && !in_ready) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_reg_buffer.sv
// Directed bench for reg_buffer (WIDTH=8, DEPTH=4, AF_LEVEL=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_reg_buffer;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, almost_full, ovf;
  logic [7:0] out_data;
  logic [2:0] count;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  always #5 clk = ~clk;

  reg_buffer #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .almost_full(almost_full),
    .ovf        (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"},     count, 0);
    chk({tag, " in_ready"},  in_ready, 1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"},  out_data, 0);
    chk({tag, " af"},        almost_full, 0);
    chk({tag, " ovf"},       ovf, 0);
  endtask

  task automatic push_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    step();
    rst = 1'b0;
    chk_reset_state("reset");

    // Fill with consumer stalled: count climbs, almost_full at 3, in_ready drops at 4
    for (int i = 0; i < 4; i++) begin
      push_word(fill[i]);
      chk("fill count", count, i + 1);
      chk("fill af", almost_full, (i + 1 >= 3) ? 1 : 0);
      chk("fill in_ready", in_ready, (i == 3) ? 0 : 1);
      chk("fill head", out_data, 8'h11);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain valid", out_valid, 1);
      chk("drain data", out_data, fill[i]);
      step();
    end
    out_ready = 1'b0;
    chk("drained valid", out_valid, 0);
    chk("drained data", out_data, 0);
    chk("drained count", count, 0);

    // Latency: pushed word not visible before the edge, visible after it
    in_valid = 1'b1; in_data = 8'h7E;
    #2;
    chk("lat pre valid", out_valid, 0);
    chk("lat pre data", out_data, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat post valid", out_valid, 1);
    chk("lat post data", out_data, 8'h7E);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lat pop count", count, 0);

    // Full + pop + push same cycle: pop happens, push refused, ovf set
    for (int i = 0; i < 4; i++) push_word(fill[i]);
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    chk("full in_ready", in_ready, 0);
    chk("full ovf pre", ovf, 0);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("ovf count", count, 3);
    chk("ovf set", ovf, 1);
    chk("ovf head", out_data, 8'h22);
    step();
    chk("ovf sticky", ovf, 1);
    chk("ovf idle count", count, 3);

    // Flush with a push offered: everything cleared, push ignored
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_reset_state("flush");

    // Steady push+pop at count 2 across pointer wrap
    push_word(8'hB0);
    push_word(8'hB1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i); out_ready = 1'b1;
      chk("stream data", out_data, (i < 2) ? (8'hB0 + i) : (8'hA0 + i - 2));
      step();
      chk("stream count", count, 2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream tail0", out_data, 8'hA8);

    // Reset mid-stream beats push and pop
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hCC; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_reset_state("rst mid");

    push_word(8'h5A);
    chk("post rst count", count, 1);
    chk("post rst data", out_data, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
